clock_divider_prog: RTL and testbench

Runtime-programmable, single-channel successor to the fixed clock divider. It divides `clock_in` by a divisor loaded through a valid/ready handshake. The divisor can be any value from 2 to 2^WIDTH-1. Each output period is near 50 % duty, and the block emits a one-cycle `tick` strobe aligned to every rising edge of `clock_out`. A new divisor takes effect only at a period boundary, so the output never glitches. The block sits at the clock-generation front of the design and feeds both fabric logic (`tick` as a clock enable) and pins (`clock_out`).

---
 rtl/clock_divider_prog.sv | 115 +++++++++++
 tb/tb_clock_divider_prog.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_prog.sv
// ---------------------------------------------------------------------------
// clock_divider_prog
// Runtime-programmable clock divider. Divides clock_in by a divisor loaded
// over a valid/ready handshake, produces a near-50 % duty clock_out and a
// one-cycle tick aligned to each clock_out rising edge. A new divisor is
// adopted only at a period boundary (or immediately while parked), so the
// output never glitches.
// ---------------------------------------------------------------------------
module clock_divider_prog #(
    parameter int WIDTH       = 28,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             clock_out,
    output logic             tick,
    output logic [WIDTH-1:0] div_active,
    output logic             err
);

    // Reject a default divisor the counter cannot represent or divide by.
    if (DEFAULT_DIV < 2 || longint'(DEFAULT_DIV) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_default
        $error("clock_divider_prog: DEFAULT_DIV must be in 2 .. 2**WIDTH-1");
    end

    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_TWO = WIDTH'(2);
    localparam logic [WIDTH-1:0] C_DEF = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div_active;
    logic [WIDTH-1:0] r_div_pending;
    logic             r_pending;
    logic             r_clock_out;
    logic             r_tick;
    logic             r_err;

    logic [WIDTH-1:0] w_last;
    logic             w_wrap;
    logic [WIDTH-1:0] w_cnt_run;
    logic [WIDTH-1:0] w_half;
    logic             w_accept;
    logic             w_div_too_small;
    logic [WIDTH-1:0] w_div_clamped;

    // div_active is always >= 2, so the subtraction cannot underflow.
    assign w_last          = r_div_active - C_ONE;
    assign w_wrap          = (r_cnt == w_last);
    assign w_cnt_run       = w_wrap ? '0 : r_cnt + C_ONE;
    assign w_half          = r_div_active >> 1;
    assign w_accept        = div_valid && !r_pending;
    assign w_div_too_small = (div_in < C_TWO);
    assign w_div_clamped   = w_div_too_small ? C_TWO : div_in;

    // Counter, output flops, divisor hand-off and sticky error.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_cnt         <= C_DEF - C_ONE;
            r_div_active  <= C_DEF;
            r_div_pending <= C_DEF;
            r_pending     <= 1'b0;
            r_clock_out   <= 1'b0;
            r_tick        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            if (en) begin
                // Running: clock_out tracks (cnt < H) one cycle ahead. On a
                // wrap the next cnt is 0, which is below any H >= 1, so the
                // old or new divisor gives the same first-cycle output.
                r_cnt       <= w_cnt_run;
                r_clock_out <= (w_cnt_run < w_half);
                r_tick      <= (w_cnt_run == '0);
                if (w_wrap && r_pending) begin
                    r_div_active <= r_div_pending;
                    r_pending    <= 1'b0;
                end
            end else begin
                // Parked: hold the counter at its last value so the first
                // running edge wraps to 0 and restarts the phase cleanly.
                r_clock_out <= 1'b0;
                r_tick      <= 1'b0;
                if (r_pending) begin
                    r_div_active <= r_div_pending;
                    r_cnt        <= r_div_pending - C_ONE;
                    r_pending    <= 1'b0;
                end else begin
                    r_cnt <= w_last;
                end
            end

            // A transfer needs pending == 0 while an apply needs pending == 1,
            // so these writes to r_pending can never collide.
            if (w_accept) begin
                r_div_pending <= w_div_clamped;
                r_pending     <= 1'b1;
                if (w_div_too_small) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign div_ready  = !r_pending;
    assign clock_out  = r_clock_out;
    assign tick       = r_tick;
    assign div_active = r_div_active;
    assign err        = r_err;

endmodule

// File: tb/tb_clock_divider_prog.sv
// ---------------------------------------------------------------------------
// tb_clock_divider_prog
// Self-checking bench for clock_divider_prog with DEFAULT_DIV = 4 on a
// 50 MHz clock. Each scenario pushes the expected {clock_out, tick,
// div_ready} sequence into a queue, then pops and compares one entry per
// clock cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clock_divider_prog;

    localparam int WIDTH = 28;

    typedef struct packed {
        logic co;
        logic tk;
        logic rdy;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             en;
    logic [WIDTH-1:0] div_in;
    logic             div_valid;
    logic             div_ready;
    logic             clock_out;
    logic             tick;
    logic [WIDTH-1:0] div_active;
    logic             err;

    exp_t sb[$];
    int   errors;
    int   checks;

    clock_divider_prog #(
        .WIDTH      (WIDTH),
        .DEFAULT_DIV(4)
    ) dut (
        .clock_in  (clk),
        .reset     (reset),
        .en        (en),
        .div_in    (div_in),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .clock_out (clock_out),
        .tick      (tick),
        .div_active(div_active),
        .err       (err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Advance one clock edge and settle past it before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_default_periods(input int n_periods);
        for (int p = 0; p < n_periods; p++) begin
            sb.push_back('{co: 1'b1, tk: 1'b1, rdy: 1'b1});
            sb.push_back('{co: 1'b1, tk: 1'b0, rdy: 1'b1});
            sb.push_back('{co: 1'b0, tk: 1'b0, rdy: 1'b1});
            sb.push_back('{co: 1'b0, tk: 1'b0, rdy: 1'b1});
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        en        = 1'b0;
        div_valid = 1'b0;
        div_in    = '0;
        step();
        step();
        checks++;
        if (div_active !== WIDTH'(4)) begin
            errors++;
            $display("FAIL reset div_active: got %0d expected 4", div_active);
        end
        checks++;
        if ({clock_out, tick, div_ready, err} !== 4'b0010) begin
            errors++;
            $display("FAIL reset outputs co/tick/rdy/err: got %b expected 0010",
                     {clock_out, tick, div_ready, err});
        end
    endtask

    task automatic test_default();
        exp_t e;
        exp_t got;
        int   idx;
        time  t_tick[$];
        reset = 1'b0;
        en    = 1'b1;
        push_default_periods(3);
        idx = 0;
        while (sb.size() > 0) begin
            step();
            e   = sb.pop_front();
            got = '{co: clock_out, tk: tick, rdy: div_ready};
            if (tick === 1'b1) t_tick.push_back($time);
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL default cycle %0d co/tick/rdy: got %b expected %b", idx, got, e);
            end
            idx++;
        end
        checks++;
        if (t_tick.size() != 3 || (t_tick[1] - t_tick[0]) != 80) begin
            errors++;
            $display("FAIL default period: got %0d ticks, expected 3 ticks 80 ns apart", t_tick.size());
        end
    endtask

    task automatic test_load5();
        exp_t e;
        exp_t got;
        bit   seen;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            step();
            if (tick === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL load5 wait for tick: got none expected one within 8 cycles");
        end
        step();                         // cnt is now 1: transfer on next edge
        div_in    = WIDTH'(5);
        div_valid = 1'b1;
        sb.push_back('{co: 1'b0, tk: 1'b0, rdy: 1'b0});
        sb.push_back('{co: 1'b0, tk: 1'b0, rdy: 1'b0});
        sb.push_back('{co: 1'b1, tk: 1'b1, rdy: 1'b1});
        sb.push_back('{co: 1'b1, tk: 1'b0, rdy: 1'b1});
        sb.push_back('{co: 1'b0, tk: 1'b0, rdy: 1'b1});
        sb.push_back('{co: 1'b0, tk: 1'b0, rdy: 1'b1});
        sb.push_back('{co: 1'b0, tk: 1'b0, rdy: 1'b1});
        sb.push_back('{co: 1'b1, tk: 1'b1, rdy: 1'b1});
        for (int idx = 0; sb.size() > 0; idx++) begin
            step();
            div_valid = 1'b0;
            e   = sb.pop_front();
            got = '{co: clock_out, tk: tick, rdy: div_ready};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL load5 cycle %0d co/tick/rdy: got %b expected %b", idx, got, e);
            end
        end
        checks++;
        if (div_active !== WIDTH'(5)) begin
            errors++;
            $display("FAIL load5 div_active: got %0d expected 5", div_active);
        end
    endtask

    task automatic test_div_zero();
        exp_t e;
        exp_t got;
        div_in    = '0;
        div_valid = 1'b1;
        sb.push_back('{co: 1'b1, tk: 1'b0, rdy: 1'b0});
        sb.push_back('{co: 1'b0, tk: 1'b0, rdy: 1'b0});
        sb.push_back('{co: 1'b0, tk: 1'b0, rdy: 1'b0});
        sb.push_back('{co: 1'b0, tk: 1'b0, rdy: 1'b0});
        sb.push_back('{co: 1'b1, tk: 1'b1, rdy: 1'b1});
        sb.push_back('{co: 1'b0, tk: 1'b0, rdy: 1'b1});
        sb.push_back('{co: 1'b1, tk: 1'b1, rdy: 1'b1});
        sb.push_back('{co: 1'b0, tk: 1'b0, rdy: 1'b1});
        for (int idx = 0; sb.size() > 0; idx++) begin
            step();
            div_valid = 1'b0;
            if (idx == 0) begin
                checks++;
                if (err !== 1'b1) begin
                    errors++;
                    $display("FAIL div0 err after transfer: got %b expected 1", err);
                end
            end
            e   = sb.pop_front();
            got = '{co: clock_out, tk: tick, rdy: div_ready};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL div0 cycle %0d co/tick/rdy: got %b expected %b", idx, got, e);
            end
        end
        checks++;
        if (div_active !== WIDTH'(2)) begin
            errors++;
            $display("FAIL div0 div_active: got %0d expected 2", div_active);
        end
    endtask

    task automatic test_ignore_busy();
        exp_t e;
        exp_t got;
        div_in    = WIDTH'(6);
        div_valid = 1'b1;
        sb.push_back('{co: 1'b1, tk: 1'b1, rdy: 1'b0});
        sb.push_back('{co: 1'b0, tk: 1'b0, rdy: 1'b0});
        sb.push_back('{co: 1'b1, tk: 1'b1, rdy: 1'b1});
        sb.push_back('{co: 1'b1, tk: 1'b0, rdy: 1'b1});
        sb.push_back('{co: 1'b1, tk: 1'b0, rdy: 1'b1});
        sb.push_back('{co: 1'b0, tk: 1'b0, rdy: 1'b1});
        sb.push_back('{co: 1'b0, tk: 1'b0, rdy: 1'b1});
        sb.push_back('{co: 1'b0, tk: 1'b0, rdy: 1'b1});
        sb.push_back('{co: 1'b1, tk: 1'b1, rdy: 1'b1});
        for (int idx = 0; sb.size() > 0; idx++) begin
            step();
            if (idx == 0) begin
                div_in = WIDTH'(9);     // offered while busy: must be ignored
            end else begin
                div_valid = 1'b0;
            end
            e   = sb.pop_front();
            got = '{co: clock_out, tk: tick, rdy: div_ready};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL ignore cycle %0d co/tick/rdy: got %b expected %b", idx, got, e);
            end
        end
        checks++;
        if (div_active !== WIDTH'(6)) begin
            errors++;
            $display("FAIL ignore div_active: got %0d expected 6", div_active);
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL ignore sticky err: got %b expected 1", err);
        end
    endtask

    task automatic test_park();
        exp_t e;
        exp_t got;
        sb.push_back('{co: 1'b1, tk: 1'b0, rdy: 1'b1});
        sb.push_back('{co: 1'b0, tk: 1'b0, rdy: 1'b1});
        sb.push_back('{co: 1'b0, tk: 1'b0, rdy: 1'b1});
        sb.push_back('{co: 1'b0, tk: 1'b0, rdy: 1'b1});
        sb.push_back('{co: 1'b1, tk: 1'b1, rdy: 1'b1});
        sb.push_back('{co: 1'b1, tk: 1'b0, rdy: 1'b1});
        sb.push_back('{co: 1'b1, tk: 1'b0, rdy: 1'b1});
        sb.push_back('{co: 1'b0, tk: 1'b0, rdy: 1'b1});
        for (int idx = 0; sb.size() > 0; idx++) begin
            step();
            if (idx == 0) en = 1'b0;    // drop enable mid-high phase
            if (idx == 3) en = 1'b1;    // after three parked edges
            e   = sb.pop_front();
            got = '{co: clock_out, tk: tick, rdy: div_ready};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL park cycle %0d co/tick/rdy: got %b expected %b", idx, got, e);
            end
        end
    endtask

    task automatic test_reset_pending();
        exp_t e;
        exp_t got;
        div_in    = WIDTH'(7);
        div_valid = 1'b1;
        step();
        div_valid = 1'b0;
        checks++;
        if (div_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstpend ready after transfer: got %b expected 0", div_ready);
        end
        reset = 1'b1;
        step();
        checks++;
        if ({div_active, div_ready, clock_out, tick, err} !== {WIDTH'(4), 4'b1000}) begin
            errors++;
            $display("FAIL rstpend after reset div_active=%0d rdy/co/tick/err=%b expected 4 and 1000",
                     div_active, {div_ready, clock_out, tick, err});
        end
        reset = 1'b0;
        push_default_periods(3);
        for (int idx = 0; sb.size() > 0; idx++) begin
            step();
            e   = sb.pop_front();
            got = '{co: clock_out, tk: tick, rdy: div_ready};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL rstpend cycle %0d co/tick/rdy: got %b expected %b", idx, got, e);
            end
        end
        checks++;
        if (div_active !== WIDTH'(4)) begin
            errors++;
            $display("FAIL rstpend div_active later: got %0d expected 4", div_active);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_default();
        test_load5();
        test_div_zero();
        test_ignore_busy();
        test_park();
        test_reset_pending();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
